sprite_blitter: RTL and testbench



---
 rtl/sprite_blit_pkg.sv | 25 ++
 rtl/sprite_blit_delay.sv | 83 ++++++++
 rtl/sprite_blitter.sv | 150 +++++++++++++++
 tb/tb_sprite_blitter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sprite_blit_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sprite_blit_pkg
//  Purpose : Shared state encoding, pass tags and screen defaults for the
//            sprite blitter.
//  Rev     : 1.0  initial release
// ============================================================================
package sprite_blit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERASE = 3'd1,
        ST_DRAW  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } blit_state_e;

    localparam logic [2:0] TRANSPARENT_COLOR = 3'b000;
    localparam logic       PASS_ERASE        = 1'b0;
    localparam logic       PASS_DRAW         = 1'b1;
    localparam int         DEF_SCREEN_W      = 320;
    localparam int         DEF_SCREEN_H      = 240;

endpackage
`default_nettype wire

// File: rtl/sprite_blit_delay.sv
`default_nettype none
// ============================================================================
//  Module  : sprite_blit_delay
//  Purpose : Aligns issued pixel info with the lookup latency and registers
//            the VGA write. Optional macro SPRITE_BLIT_TRANSPARENT_EN.
//  Rev     : 1.0  initial release
// ============================================================================
module sprite_blit_delay
    import sprite_blit_pkg::*;
#(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 3,
    parameter int BG_LAT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_valid,
    input  logic               i_pass,
    input  logic               i_onscreen,
    input  logic [X_W-1:0]     i_x,
    input  logic [Y_W-1:0]     i_y,
    input  logic [COLOR_W-1:0] i_bg_color,
    input  logic [COLOR_W-1:0] i_spr_color,
    output logic               o_plot,
    output logic [X_W-1:0]     o_x,
    output logic [Y_W-1:0]     o_y,
    output logic [COLOR_W-1:0] o_color
);

    localparam int c_PW = 3 + X_W + Y_W;

    // Element k is the issued pixel delayed by k cycles; the last tap lines up
    // with the colour returned by the external lookups.
    logic [c_PW-1:0] w_chain [0:BG_LAT];

    assign w_chain[0] = {i_valid, i_pass, i_onscreen, i_x, i_y};

    for (genvar k = 1; k <= BG_LAT; k++) begin : g_stage
        logic [c_PW-1:0] r_stage;
        always_ff @(posedge clk) begin
            if (reset) r_stage <= '0;
            else       r_stage <= w_chain[k-1];
        end
        assign w_chain[k] = r_stage;
    end

    logic               w_valid;
    logic               w_pass;
    logic               w_onscreen;
    logic [X_W-1:0]     w_x;
    logic [Y_W-1:0]     w_y;
    logic [COLOR_W-1:0] w_color;
    logic               w_visible;

    assign {w_valid, w_pass, w_onscreen, w_x, w_y} = w_chain[BG_LAT];
    assign w_color = (w_pass == PASS_DRAW) ? i_spr_color : i_bg_color;

`ifdef SPRITE_BLIT_TRANSPARENT_EN
    assign w_visible = w_valid && w_onscreen &&
                       !((w_pass == PASS_DRAW) && (i_spr_color == COLOR_W'(TRANSPARENT_COLOR)));
`else
    assign w_visible = w_valid && w_onscreen;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            o_plot  <= 1'b0;
            o_x     <= '0;
            o_y     <= '0;
            o_color <= '0;
        end else begin
            o_plot <= w_visible;
            if (w_valid) begin
                o_x     <= w_x;
                o_y     <= w_y;
                o_color <= w_color;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module  : sprite_blitter
//  Purpose : Erase-then-draw sprite blitter, one clipped pixel write per cycle.
//            Optional macro SPRITE_BLIT_TRANSPARENT_EN skips transparent pixels.
//  Rev     : 1.0  initial release
// ============================================================================
module sprite_blitter
    import sprite_blit_pkg::*;
#(
    parameter int SPR_W    = 4,
    parameter int SPR_H    = 4,
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOR_W  = 3,
    parameter int BG_LAT   = 1,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int ADDR_W   = ($clog2(SPR_W*SPR_H) < 1) ? 1 : $clog2(SPR_W*SPR_H)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               erase,
    input  logic [X_W-1:0]     old_x,
    input  logic [Y_W-1:0]     old_y,
    input  logic [X_W-1:0]     new_x,
    input  logic [Y_W-1:0]     new_y,
    output logic               busy,
    output logic               done,
    output logic [X_W-1:0]     rd_x,
    output logic [Y_W-1:0]     rd_y,
    input  logic [COLOR_W-1:0] bg_color,
    output logic [ADDR_W-1:0]  spr_addr,
    input  logic [COLOR_W-1:0] spr_color,
    output logic               plot,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic [COLOR_W-1:0] color_out
);

    localparam logic [2:0] c_IDLE       = ST_IDLE;
    localparam logic [2:0] c_ERASE      = ST_ERASE;
    localparam logic [2:0] c_DRAW       = ST_DRAW;
    localparam logic [2:0] c_DRAIN      = ST_DRAIN;
    localparam logic [2:0] c_DONE       = ST_DONE;
    localparam logic [3:0] c_COL_LAST   = 4'(SPR_W - 1);
    localparam logic [3:0] c_ROW_LAST   = 4'(SPR_H - 1);
    localparam logic [2:0] c_DRAIN_LAST = 3'(BG_LAT);

    logic [2:0]     r_state;
    logic [3:0]     r_col;
    logic [3:0]     r_row;
    logic [2:0]     r_drain;
    logic [X_W-1:0] r_old_x;
    logic [X_W-1:0] r_new_x;
    logic [Y_W-1:0] r_old_y;
    logic [Y_W-1:0] r_new_y;

    logic           w_issue;
    logic           w_pass;
    logic           w_onscreen;
    logic [X_W:0]   w_sum_x;
    logic [Y_W:0]   w_sum_y;

    assign w_issue = (r_state == c_ERASE) || (r_state == c_DRAW);
    assign w_pass  = (r_state == c_DRAW) ? PASS_DRAW : PASS_ERASE;

    // One guard bit on the sums so a sprite hanging off the edge clips
    // instead of wrapping back onto the screen.
    assign w_sum_x = {1'b0, (r_state == c_ERASE) ? r_old_x : r_new_x} + (X_W+1)'(r_col);
    assign w_sum_y = {1'b0, (r_state == c_ERASE) ? r_old_y : r_new_y} + (Y_W+1)'(r_row);
    assign w_onscreen = (w_sum_x < (X_W+1)'(SCREEN_W)) && (w_sum_y < (Y_W+1)'(SCREEN_H));

    assign rd_x     = w_sum_x[X_W-1:0];
    assign rd_y     = w_sum_y[Y_W-1:0];
    assign spr_addr = ADDR_W'(8'(r_row) * 8'(SPR_W) + 8'(r_col));
    assign busy     = (r_state != c_IDLE);
    assign done     = (r_state == c_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_drain <= '0;
            r_old_x <= '0;
            r_old_y <= '0;
            r_new_x <= '0;
            r_new_y <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_old_x <= old_x;
                        r_old_y <= old_y;
                        r_new_x <= new_x;
                        r_new_y <= new_y;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_state <= erase ? c_ERASE : c_DRAW;
                    end
                end
                c_ERASE, c_DRAW: begin
                    if (r_col == c_COL_LAST) begin
                        r_col <= '0;
                        if (r_row == c_ROW_LAST) begin
                            r_row   <= '0;
                            r_drain <= '0;
                            r_state <= (r_state == c_ERASE) ? c_DRAW : c_DRAIN;
                        end else begin
                            r_row <= r_row + 4'd1;
                        end
                    end else begin
                        r_col <= r_col + 4'd1;
                    end
                end
                c_DRAIN: begin
                    if (r_drain == c_DRAIN_LAST) r_state <= c_DONE;
                    else                         r_drain <= r_drain + 3'd1;
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    sprite_blit_delay #(
        .X_W     (X_W),
        .Y_W     (Y_W),
        .COLOR_W (COLOR_W),
        .BG_LAT  (BG_LAT)
    ) u_delay (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (w_issue),
        .i_pass      (w_pass),
        .i_onscreen  (w_onscreen),
        .i_x         (rd_x),
        .i_y         (rd_y),
        .i_bg_color  (bg_color),
        .i_spr_color (spr_color),
        .o_plot      (plot),
        .o_x         (x_out),
        .o_y         (y_out),
        .o_color     (color_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sprite_blitter
//  Purpose : Drives two blitters (lookup latency 1 and 3) with identical
//            requests and compares every cycle against a pixel-list model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_sprite_blitter;
    import sprite_blit_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       erase = 1'b0;
    logic [8:0] old_x = '0, new_x = '0;
    logic [7:0] old_y = '0, new_y = '0;

    // index 0: BG_LAT=1, index 1: BG_LAT=3
    logic       busy [2], done [2], plot [2];
    logic [8:0] rd_x [2], x_out [2];
    logic [7:0] rd_y [2], y_out [2];
    logic [3:0] spr_addr [2];
    logic [2:0] bg_color [2], spr_color [2], color_out [2];

    logic [2:0] rom [16];
    logic [8:0] hx [2][3];
    logic [7:0] hy [2][3];
    logic [3:0] ha [2][3];

    logic       e_plot [2][64];
    logic [8:0] e_x [2][64];
    logic [7:0] e_y [2][64];
    logic [2:0] e_c [2][64];
    int         e_done [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_blitter #(.BG_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .erase(erase),
        .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
        .busy(busy[0]), .done(done[0]), .rd_x(rd_x[0]), .rd_y(rd_y[0]),
        .bg_color(bg_color[0]), .spr_addr(spr_addr[0]), .spr_color(spr_color[0]),
        .plot(plot[0]), .x_out(x_out[0]), .y_out(y_out[0]), .color_out(color_out[0])
    );

    sprite_blitter #(.BG_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .start(start), .erase(erase),
        .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
        .busy(busy[1]), .done(done[1]), .rd_x(rd_x[1]), .rd_y(rd_y[1]),
        .bg_color(bg_color[1]), .spr_addr(spr_addr[1]), .spr_color(spr_color[1]),
        .plot(plot[1]), .x_out(x_out[1]), .y_out(y_out[1]), .color_out(color_out[1])
    );

    function automatic logic [2:0] bg_fn(input logic [8:0] x, input logic [7:0] y);
        return 3'(({23'd0, x} * 32'd5) + ({24'd0, y} * 32'd3) + {26'd0, x[8:3]});
    endfunction

    // Background and sprite memories with latency 1 (index 0) and 3 (index 1).
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            hx[d][0] <= rd_x[d];
            hy[d][0] <= rd_y[d];
            ha[d][0] <= spr_addr[d];
            for (int k = 1; k < 3; k++) begin
                hx[d][k] <= hx[d][k-1];
                hy[d][k] <= hy[d][k-1];
                ha[d][k] <= ha[d][k-1];
            end
        end
    end

    assign bg_color[0]  = bg_fn(hx[0][0], hy[0][0]);
    assign spr_color[0] = rom[ha[0][0]];
    assign bg_color[1]  = bg_fn(hx[1][2], hy[1][2]);
    assign spr_color[1] = rom[ha[1][2]];

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, obs, exp);
        end
    endtask

    // Enumerate the request's pixels in order; issue slot t plots at t+lat+1.
    task automatic build(input int d, input int lat, input logic er,
                         input int ox, input int oy, input int nx, input int ny);
        int t;
        int sx, sy;
        logic [2:0] col;
        logic vis;
        for (int c = 0; c < 64; c++) e_plot[d][c] = 1'b0;
        t = 1;
        for (int p = (er ? 0 : 1); p < 2; p++) begin
            for (int r = 0; r < 4; r++) begin
                for (int cc = 0; cc < 4; cc++) begin
                    sx  = (p == 1 ? nx : ox) + cc;
                    sy  = (p == 1 ? ny : oy) + r;
                    col = (p == 1) ? rom[r*4 + cc] : bg_fn(9'(sx), 8'(sy));
                    vis = (sx < 320) && (sy < 240);
`ifdef SPRITE_BLIT_TRANSPARENT_EN
                    if (p == 1 && col == 3'd0) vis = 1'b0;
`endif
                    if (vis) begin
                        e_plot[d][t+lat+1] = 1'b1;
                        e_x[d][t+lat+1]    = 9'(sx);
                        e_y[d][t+lat+1]    = 8'(sy);
                        e_c[d][t+lat+1]    = col;
                    end
                    t++;
                end
            end
        end
        e_done[d] = (t - 1) + lat + 2;
    endtask

    // ign > 0: a second start pulse in that cycle, which must be ignored.
    task automatic run_req(input logic er, input int ox, input int oy,
                           input int nx, input int ny, input int ign);
        build(0, 1, er, ox, oy, nx, ny);
        build(1, 3, er, ox, oy, nx, ny);
        @(posedge clk); #1;
        erase = er; old_x = 9'(ox); old_y = 8'(oy); new_x = 9'(nx); new_y = 8'(ny);
        start = 1'b1;
        for (int c = 1; c <= e_done[1] + 4; c++) begin
            @(posedge clk); #1;
            if (c == 1 || c == ign + 1) start = 1'b0;
            if (c == ign) begin
                start = 1'b1; erase = 1'b1; new_x = 9'd100; new_y = 8'd100;
            end
            for (int d = 0; d < 2; d++) begin
                chk("busy", d, 32'(busy[d]), 32'(c <= e_done[d]));
                chk("done", d, 32'(done[d]), 32'(c == e_done[d]));
                chk("plot", d, 32'(plot[d]), 32'(e_plot[d][c]));
                if (e_plot[d][c]) begin
                    chk("x_out", d, 32'(x_out[d]), 32'(e_x[d][c]));
                    chk("y_out", d, 32'(y_out[d]), 32'(e_y[d][c]));
                    chk("color_out", d, 32'(color_out[d]), 32'(e_c[d][c]));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 3'($urandom_range(1, 7));
        rom[5] = 3'd0;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 3; k++) begin
                hx[d][k] = '0; hy[d][k] = '0; ha[d][k] = '0;
            end

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", d, 32'(busy[d]), 32'd0);
            chk("rst_done", d, 32'(done[d]), 32'd0);
            chk("rst_plot", d, 32'(plot[d]), 32'd0);
            chk("rst_rd_x", d, 32'(rd_x[d]), 32'd0);
            chk("rst_rd_y", d, 32'(rd_y[d]), 32'd0);
            chk("rst_spr_addr", d, 32'(spr_addr[d]), 32'd0);
            chk("rst_x_out", d, 32'(x_out[d]), 32'd0);
            chk("rst_y_out", d, 32'(y_out[d]), 32'd0);
            chk("rst_color_out", d, 32'(color_out[d]), 32'd0);
        end

        run_req(1'b0, 0, 0, 10, 20, 5);
        run_req(1'b1, 10, 20, 11, 20, 7);
        run_req(1'b0, 0, 0, 318, 238, -1);

        // Abort a draw with reset in cycle 8.
        @(posedge clk); #1;
        erase = 1'b0; new_x = 9'd10; new_y = 8'd20; start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (c == 8) reset = 1'b1;
            if (c == 9) reset = 1'b0;
            if (c >= 9) begin
                for (int d = 0; d < 2; d++) begin
                    chk("abort_plot", d, 32'(plot[d]), 32'd0);
                    chk("abort_busy", d, 32'(busy[d]), 32'd0);
                    chk("abort_done", d, 32'(done[d]), 32'd0);
                end
            end
        end

        for (int i = 0; i < 6; i++)
            run_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 330)), int'($urandom_range(0, 250)),
                    int'($urandom_range(0, 330)), int'($urandom_range(0, 250)), int'($urandom_range(2, 12)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
